// File: rtl/aes_key_sched_ctrl_if.sv
// Command handshake plus the strobe/control bundle between the AES key-schedule
// controller (slave side) and its requester / datapath / key_expansion (master side).
interface aes_key_sched_ctrl_if #(
    parameter int IDX_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             ke_set_new_key;
    logic             ke_start_enc;
    logic             ke_ready_enc;
    logic             ke_start_dec;
    logic             ke_ready_dec;
    logic             dp_load;
    logic             dp_round_en;
    logic [IDX_W-1:0] dp_round_idx;
    logic             dp_final;
    logic             dp_decrypt;
    logic             busy;
    logic             key_ready;
    logic             done;
    logic             err;

    modport slave (
        input  cmd_valid, cmd_op,
        output cmd_ready, ke_set_new_key, ke_start_enc, ke_ready_enc, ke_start_dec,
               ke_ready_dec, dp_load, dp_round_en, dp_round_idx, dp_final, dp_decrypt,
               busy, key_ready, done, err
    );

    modport master (
        output cmd_valid, cmd_op,
        input  cmd_ready, ke_set_new_key, ke_start_enc, ke_ready_enc, ke_start_dec,
               ke_ready_dec, dp_load, dp_round_en, dp_round_idx, dp_final, dp_decrypt,
               busy, key_ready, done, err
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for the AES round datapath and key_expansion: turns load/encrypt/decrypt
// commands into registered edge strobes, round load/enable/index and key-valid tracking.
module aes_key_sched_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_key_sched_ctrl_if.slave  bus
);
    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_LOAD       = 4'd1;
    localparam logic [3:0] ST_PREP_START = 4'd2;
    localparam logic [3:0] ST_PREP_STEP  = 4'd3;
    localparam logic [3:0] ST_PREP_GAP   = 4'd4;
    localparam logic [3:0] ST_START      = 4'd5;
    localparam logic [3:0] ST_STEP       = 4'd6;
    localparam logic [3:0] ST_APPLY      = 4'd7;
    localparam logic [3:0] ST_FINISH     = 4'd8;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ENC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [IDX_W-1:0] LAST_ROUND  = IDX_W'(NUM_ROUNDS);
    localparam logic [IDX_W-1:0] FIRST_ROUND = '0;

    logic [3:0]       state_q, state_d;
    logic [IDX_W-1:0] round_q, round_d;
    logic [1:0]       op_q, op_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             set_key_q, set_key_d;
    logic             start_enc_q, start_enc_d;
    logic             ready_enc_q, ready_enc_d;
    logic             start_dec_q, start_dec_d;
    logic             ready_dec_q, ready_dec_d;
    logic             load_q, load_d;
    logic             round_en_q, round_en_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             final_q, final_d;
    logic             decrypt_q, decrypt_d;
    logic             key_ready_q, key_ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic             is_dec;
    logic             last_round;
    logic [IDX_W-1:0] round_step;

    assign accept     = bus.cmd_valid && cmd_ready_q;
    assign is_dec     = (op_q == OP_DEC);
    assign last_round = is_dec ? (round_q == FIRST_ROUND) : (round_q == LAST_ROUND);
    assign round_step = is_dec ? (round_q - 1'b1) : (round_q + 1'b1);

    // Outputs are derived from the current state and registered, so every strobe
    // appears one cycle after the state that requests it.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        op_d        = op_q;
        set_key_d   = 1'b0;
        start_enc_d = 1'b0;
        ready_enc_d = 1'b0;
        start_dec_d = 1'b0;
        ready_dec_d = 1'b0;
        load_d      = 1'b0;
        round_en_d  = 1'b0;
        idx_d       = idx_q;
        final_d     = 1'b0;
        decrypt_d   = decrypt_q;
        key_ready_d = key_ready_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                decrypt_d = 1'b0;
                if (accept) begin
                    op_d      = bus.cmd_op;
                    decrypt_d = (bus.cmd_op == OP_DEC);
                    case (bus.cmd_op)
                        OP_LOAD: state_d = ST_LOAD;
                        OP_ENC: begin
                            state_d = ST_START;
                            round_d = FIRST_ROUND;
                        end
                        OP_DEC: begin
                            // key_expansion must first walk forward to the last round key
                            state_d = key_ready_q ? ST_START : ST_PREP_START;
                            round_d = key_ready_q ? LAST_ROUND : FIRST_ROUND;
                        end
                        default: state_d = ST_FINISH;
                    endcase
                end
            end
            ST_LOAD: begin
                set_key_d   = 1'b1;
                key_ready_d = 1'b0;
                state_d     = ST_FINISH;
            end
            ST_PREP_START: begin
                start_enc_d = 1'b1;
                round_d     = FIRST_ROUND + 1'b1;
                state_d     = ST_PREP_STEP;
            end
            ST_PREP_STEP: begin
                ready_enc_d = 1'b1;
                state_d     = ST_PREP_GAP;
            end
            ST_PREP_GAP: begin
                if (round_q == LAST_ROUND) begin
                    key_ready_d = 1'b1;
                    state_d     = ST_START;
                end else begin
                    round_d = round_q + 1'b1;
                    state_d = ST_PREP_STEP;
                end
            end
            ST_START: begin
                start_enc_d = !is_dec;
                start_dec_d = is_dec;
                load_d      = 1'b1;
                idx_d       = round_q;
                round_d     = round_step;
                state_d     = ST_STEP;
            end
            ST_STEP: begin
                ready_enc_d = !is_dec;
                ready_dec_d = is_dec;
                state_d     = ST_APPLY;
            end
            ST_APPLY: begin
                round_en_d = 1'b1;
                idx_d      = round_q;
                final_d    = last_round;
                if (last_round) begin
                    state_d = ST_FINISH;
                end else begin
                    round_d = round_step;
                    state_d = ST_STEP;
                end
            end
            ST_FINISH: begin
                err_d   = (op_q == OP_RSVD);
                done_d  = (op_q != OP_RSVD);
                if (op_q == OP_ENC) begin
                    key_ready_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready_d = (state_q == ST_IDLE) && !accept;
    assign busy_d      = !cmd_ready_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            round_q     <= '0;
            op_q        <= OP_LOAD;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            set_key_q   <= 1'b0;
            start_enc_q <= 1'b0;
            ready_enc_q <= 1'b0;
            start_dec_q <= 1'b0;
            ready_dec_q <= 1'b0;
            load_q      <= 1'b0;
            round_en_q  <= 1'b0;
            idx_q       <= '0;
            final_q     <= 1'b0;
            decrypt_q   <= 1'b0;
            key_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            op_q        <= op_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            set_key_q   <= set_key_d;
            start_enc_q <= start_enc_d;
            ready_enc_q <= ready_enc_d;
            start_dec_q <= start_dec_d;
            ready_dec_q <= ready_dec_d;
            load_q      <= load_d;
            round_en_q  <= round_en_d;
            idx_q       <= idx_d;
            final_q     <= final_d;
            decrypt_q   <= decrypt_d;
            key_ready_q <= key_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.cmd_ready      = cmd_ready_q;
    assign bus.busy           = busy_q;
    assign bus.ke_set_new_key = set_key_q;
    assign bus.ke_start_enc   = start_enc_q;
    assign bus.ke_ready_enc   = ready_enc_q;
    assign bus.ke_start_dec   = start_dec_q;
    assign bus.ke_ready_dec   = ready_dec_q;
    assign bus.dp_load        = load_q;
    assign bus.dp_round_en    = round_en_q;
    assign bus.dp_round_idx   = idx_q;
    assign bus.dp_final       = final_q;
    assign bus.dp_decrypt     = decrypt_q;
    assign bus.key_ready      = key_ready_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
endmodule
